// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM word-fetch arbiter.
//   state_t   : transaction sequencer states
//   port_id_t : requester identifier (0 = instruction fetch, 1 = data load)
package rom_fetch_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/rom_word_fetch_arb_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]   : request vector
//   last_grant : port granted most recently
//   grant[1:0] : one-hot grant, zero when nobody requests
//   grant_id   : index of the granted port (0 when nobody requests)
module rr_arb2
    import rom_fetch_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic [1:0] grant,
    output port_id_t   grant_id
);

    always_comb begin
        grant_id = 1'b0;
        // On a tie the port that was not served last time wins.
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end

        grant = 2'b00;
        if (req != 2'b00) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/rom_word_fetch_arb.sv
// Shares a byte-wide combinational ROM between an instruction-fetch port (0)
// and a data-load port (1). Each accepted request reads the four bytes of the
// aligned word containing its address and returns them little-endian.
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqN_valid/addr/ready  : request handshake; ready is a same-cycle accept
//   rspN_valid, rsp_data   : one-cycle response strobe, shared data word
//   busy                   : high while a transaction is in FETCH or RESP
//   rom_addr, rom_data     : ROM byte address out, read data in
module rom_word_fetch_arb
    import rom_fetch_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BYTE_W-1:0] rom_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [ADDR_W-1:CNT_W]     r_base;      // word-aligned base, low bits implied zero
    logic [ADDR_W-1:0]         r_rom_addr;
    logic [WORD_W-1:0]         r_word;
    logic [WORD_W-1:0]         r_rsp_data;
    port_id_t                  r_owner;
    port_id_t                  r_last_grant;
    logic                      r_rsp0_valid;
    logic                      r_rsp1_valid;
    logic                      r_busy;

    logic [1:0]                w_grant;
    port_id_t                  w_grant_id;
    logic [ADDR_W-1:0]         w_winner_addr;
    logic [WORD_W-1:0]         w_word_next;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    assign w_winner_addr = w_grant_id ? req1_addr : req0_addr;

    // Assembly word with the current ROM byte merged into lane r_cnt.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign w_word_next[gi*BYTE_W +: BYTE_W] =
                (r_cnt == CNT_W'(gi)) ? rom_data : r_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_rom_addr   <= '0;
            r_word       <= '0;
            r_rsp_data   <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_base       <= w_winner_addr[ADDR_W-1:CNT_W];
                        r_rom_addr   <= {w_winner_addr[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};
                        r_owner      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    r_word <= w_word_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        // Publish the completed word only now so rsp_data stays
                        // stable between response strobes.
                        r_rsp_data   <= w_word_next;
                        r_rsp0_valid <= (r_owner == 1'b0);
                        r_rsp1_valid <= (r_owner == 1'b1);
                        r_rom_addr   <= '0;
                        r_state      <= RESP;
                    end else begin
                        // Offset stays inside the word: no carry into r_base.
                        r_rom_addr <= {r_base, r_cnt + 1'b1};
                    end
                end
                RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = (r_state == IDLE) && w_grant[0];
    assign req1_ready = (r_state == IDLE) && w_grant[1];
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = r_busy;
    assign rom_addr   = r_rom_addr;

endmodule

// File: tb/tb_rom_word_fetch_arb.sv
module tb_rom_word_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [10:0] req0_addr = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [10:0] req1_addr = '0;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // ROM image: 0x01 at 0x000/0x010/0x020/0x030, zero elsewhere.
    assign rom_data = (rom_addr == 11'h000 || rom_addr == 11'h010 ||
                       rom_addr == 11'h020 || rom_addr == 11'h030) ? 8'h01 : 8'h00;

    rom_word_fetch_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input int port, input logic v, input logic [10:0] a);
        if (port == 0) begin
            req0_valid = v;
            req0_addr  = a;
        end else begin
            req1_valid = v;
            req1_addr  = a;
        end
    endtask

    // Entered 1 time unit after a rising edge with the DUT idle; leaves at the
    // same phase of the cycle following the response.
    task automatic txn(input int port, input logic [10:0] addr,
                       input logic [31:0] exp_word, input logic [10:0] addr_after);
        logic [10:0] ea;
        drive_req(port, 1'b1, addr);
        #3;
        chk("ready_win",  (port == 0) ? req0_ready : req1_ready, 1);
        chk("ready_lose", (port == 0) ? req1_ready : req0_ready, 0);
        chk("idle_busy",  busy, 0);
        @(posedge clk); #1;
        drive_req(port, 1'b0, addr_after);
        for (int i = 0; i < 4; i++) begin
            ea = {addr[10:2], 2'(i)};
            #3;
            chk("fetch_addr",  rom_addr, ea);
            chk("fetch_busy",  busy, 1);
            chk("fetch_rsp",   {rsp1_valid, rsp0_valid}, 0);
            chk("fetch_ready", {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
        end
        #3;
        chk("rsp_valid", {rsp1_valid, rsp0_valid}, (port == 0) ? 2'b01 : 2'b10);
        chk("rsp_data",  rsp_data, exp_word);
        chk("rsp_busy",  busy, 1);
        @(posedge clk); #1;
        #3;
        chk("post_busy", busy, 0);
        chk("post_rsp",  {rsp1_valid, rsp0_valid}, 0);
        chk("rsp_hold",  rsp_data, exp_word);
        $display("txn port=%0d addr=%h word=%h", port, addr, rsp_data);
        @(posedge clk); #1;
    endtask

    int gp[8];
    int gc[8];
    int ng;
    int nr;
    logic [31:0] held;
    logic seen;

    initial begin
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        chk("rst_busy",  busy, 0);
        chk("rst_addr",  rom_addr, 0);
        chk("rst_data",  rsp_data, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rsp",   {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Aligned fetch on port 0, unaligned on port 1
        txn(0, 11'h000, 32'h0000_0001, 11'h000);
        txn(1, 11'h013, 32'h0000_0001, 11'h013);

        // Asynchronous reset while cnt==2
        drive_req(0, 1'b1, 11'h010);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 11'h010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("abort_pre_addr", rom_addr, 11'h012);
        chk("abort_pre_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_data", rsp_data, 0);
        chk("abort_rsp",  {rsp1_valid, rsp0_valid}, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 11'h020, 32'h0000_0001, 11'h020);

        // Top of ROM, then address changed after accept
        txn(0, 11'h7FC, 32'h0000_0000, 11'h7FC);
        txn(0, 11'h004, 32'h0000_0000, 11'h030);

        // Contention from reset: both ports held valid
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_req(0, 1'b1, 11'h004);
        drive_req(1, 1'b1, 11'h020);
        ng = 0;
        nr = 0;
        seen = 1'b0;
        held = '0;
        for (int c = 0; c < 30; c++) begin
            #3;
            chk("grant_onehot", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                if (ng < 8) begin
                    gp[ng] = req1_ready ? 1 : 0;
                    gc[ng] = c;
                end
                ng++;
            end
            if (rsp0_valid || rsp1_valid) begin
                chk("cont_rsp_port", {rsp1_valid, rsp0_valid}, (nr % 2 == 0) ? 2'b01 : 2'b10);
                held = (nr % 2 == 0) ? 32'h0000_0000 : 32'h0000_0001;
                chk("cont_rsp_data", rsp_data, held);
                $display("txn port=%0d word=%h cycle=%0d", nr % 2, rsp_data, c);
                nr++;
                seen = 1'b1;
            end else if (seen) begin
                chk("cont_hold", rsp_data, held);
            end
            @(posedge clk); #1;
        end
        drive_req(0, 1'b0, 11'h000);
        drive_req(1, 1'b0, 11'h000);
        chk("cont_ngrants", ng, 5);
        chk("cont_nrsp", nr, 5);
        if (ng >= 5) begin
            for (int k = 0; k < 4; k++) begin
                chk("cont_order", gp[k], k % 2);
                chk("cont_gap", gc[k+1] - gc[k], 6);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_word_fetch_arb.md
Name: rom_word_fetch_arb

Overview:
- Shares the byte-wide program ROM (11-bit byte address, 8-bit combinational read data) between two requesters: port 0 = instruction fetch, port 1 = data load.
- Per accepted request, sequences four consecutive byte reads and assembles one 32-bit little-endian word.
- Sits between the core's fetch/load units and the ROM.
- Round-robin arbitration; one transaction in flight at a time.

Parameters:
- ADDR_W, 11, ROM byte-address width.
- BYTE_W, 8, ROM data width.
- BYTES_PER_WORD, 4, bytes assembled per response. Fixed at 4; any other value is unsupported.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request
- req0_addr  in  ADDR_W  port 0 byte address; low 2 bits ignored
- req0_ready  out  1  port 0 accept strobe
- req1_valid  in  1  port 1 request
- req1_addr  in  ADDR_W  port 1 byte address; low 2 bits ignored
- req1_ready  out  1  port 1 accept strobe
- rsp0_valid  out  1  port 0 response strobe
- rsp1_valid  out  1  port 1 response strobe
- rsp_data  out  32  assembled word, shared by both ports
- busy  out  1  transaction in progress
- rom_addr  out  ADDR_W  address to ROM
- rom_data  in  BYTE_W  ROM read data, combinational from rom_addr

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). Asserting rst_n=0 immediately sets:
  - state=IDLE, cnt=0, base=0, rsp_data=0, last_grant=1 (so port 0 wins the first tie);
  - all ready/rsp_valid=0, busy=0, rom_addr=0.
- Reset mid-transaction aborts it. No response is issued, and the requester must re-request.
- States: IDLE, FETCH, RESP.
- IDLE:
  - If any reqN_valid, select a winner: a single requester wins directly; on a tie, the port not equal to last_grant wins.
  - Combinationally assert reqN_ready for the winner only, in the same cycle.
  - On the edge: base <= {winner_addr[10:2],2'b00}, owner <= winner, last_grant <= winner, cnt <= 0, go to FETCH.
  - With no request: stay in IDLE, rom_addr=0.
- FETCH:
  - rom_addr = {base[10:2], cnt[1:0]}, registered fields only and glitch-free.
  - Each edge: word[8*cnt +: 8] <= rom_data; cnt <= cnt+1.
  - After capturing cnt==3, go to RESP.
  - Exactly 4 cycles. cnt wraps only inside the word, so the address never crosses into the next word.
- RESP (1 cycle):
  - rsp_data = assembled word; rsp<owner>_valid=1 for one cycle; go to IDLE.
  - rsp_data holds its value until the next RESP overwrites it.
- Latency: accept at cycle T, bytes read T+1..T+4, rsp_valid at T+5. Earliest next accept is T+6, so peak throughput is 1 word per 6 cycles.
- busy = 1 in FETCH and RESP.
- reqN_ready is never asserted outside IDLE.
- Protocol rules for requesters:
  - Hold reqN_valid and reqN_addr stable until reqN_ready.
  - reqN_addr is sampled only in the accept cycle; changes after accept have no effect.
  - Dropping valid before ready is legal, and the request is simply not served.
- Top address 0x7FC..0x7FF is fetched normally; no wrap to 0x000 occurs within a word.
- A request from the port that was just served, arriving again, competes normally. Under contention, ports strictly alternate.

Decomposition:
- Package rom_fetch_pkg:
  - state enum (IDLE, FETCH, RESP);
  - localparams WORD_W=32, BYTES_PER_WORD=4, CNT_W=2;
  - port-id typedef (1 bit).
- Sub-module rr_arb2:
  - Inputs: req[1:0], last_grant. Outputs: one-hot grant[1:0], grant_id.
  - Combinational, instantiated once. The top level holds the FSM, counter and assembly register.

Test Plan:
- Stimulus: ROM model with 0x01 at 0x000/0x010/0x020/0x030, else 0; req0 addr 0x000 at T. Required: req0_ready at T; rom_addr 0x000,0x001,0x002,0x003 on T+1..T+4; rsp0_valid at T+5 with rsp_data=0x00000001; busy high T+1..T+5.
- Stimulus: req1 addr 0x013 (unaligned). Required: fetch uses base 0x010; rsp1_valid with rsp_data=0x00000001; rsp0_valid stays 0.
- Stimulus: req0 and req1 both held valid continuously, addrs 0x004 and 0x020, starting from reset. Required: grants go 0,1,0,1, six cycles apart; port 0 responses=0x00000000, port 1 responses=0x00000001; rsp_data unchanged between strobes.
- Stimulus: req0 addr 0x7FC. Required: rom_addr sequence 0x7FC..0x7FF, never 0x000; rsp_data=0x00000000.
- Stimulus: rst_n pulsed low for half a cycle during FETCH cnt=2. Required: busy, rom_addr and rsp_data go to 0 immediately and asynchronously; no rsp_valid follows; a new req0 is accepted on the first IDLE cycle after release.
- Stimulus: req0_addr changed after accept, during FETCH. Required: fetch addresses remain those of the originally sampled base.
